imul_mac: RTL

Sequencing and accumulation stage wrapped around the 4-bit combinational array multiplier `IMUL`. It accepts operand nibble pairs over a valid/ready handshake and registers them onto the multiplier inputs. One cycle later it consumes the 8-bit product and adds it into an accumulator. After `COUNT` products it presents the dot-product sum downstream over a second valid/ready handshake.

---
 rtl/imul_mac.sv | 137 +++++++++++++
 1 files changed

// File: rtl/imul_mac.sv
// imul_mac: operand sequencer and dot-product accumulator around the 4x4
// combinational array multiplier IMUL.
//
// Operand pairs are accepted over a valid/ready handshake and registered onto
// the multiplier inputs (oA/oB). The product returned on iProduct is added to
// the accumulator one edge later. After COUNT products the sum is held on oSum
// with oValid=1 until the downstream takes it with iReady.
//
// Build option:
//   IMUL_MAC_SATURATE_EN  - when defined, a carry out of the accumulator
//                           clamps oSum to all-ones for the rest of the
//                           result; when undefined the sum wraps.
module imul_mac #(
    parameter int ACC_WIDTH = 12,   // 8..16
    parameter int COUNT     = 4     // 1..15
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [3:0]           iA,
    input  logic [3:0]           iB,
    output logic [3:0]           oA,
    output logic [3:0]           oB,
    input  logic [7:0]           iProduct,
    output logic [ACC_WIDTH-1:0] oSum,
    output logic                 oValid,
    input  logic                 iReady,
    output logic                 oOverflow
);

    // Operand pair as held on the multiplier inputs.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } opnd_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    // in_cnt value at which the next accept is the final one of the result.
    localparam logic [3:0] LAST_CNT = 4'(COUNT - 1);

    state_t               state, state_nxt;
    opnd_t                opnd_q;
    logic [3:0]           in_cnt;
    logic                 mul_v;
    logic                 accept;
    logic                 xfer;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] acc_nxt;

    assign accept = iValid & oReady;
    assign xfer   = (state == OUT) & iReady;

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state: the last accept goes through one DRAIN cycle so its
    // product is in the sum before the result is presented.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && in_cnt == LAST_CNT) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (iReady) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Handshake outputs are pure decodes of the state register.
    always_comb begin
        oReady = 1'b0;
        oValid = 1'b0;
        case (state)
            RUN:     oReady = 1'b1;
            OUT:     oValid = 1'b1;
            default: ;
        endcase
    end

    // Operand register and accept counter; mul_v marks that iProduct this
    // cycle belongs to a freshly accepted pair.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            opnd_q <= '0;
            in_cnt <= '0;
            mul_v  <= 1'b0;
        end else begin
            mul_v <= accept;
            if (accept) begin
                opnd_q <= '{a: iA, b: iB};
                in_cnt <= in_cnt + 4'd1;
            end else if (xfer) begin
                in_cnt <= '0;
            end
        end
    end

    assign oA = opnd_q.a;
    assign oB = opnd_q.b;

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext = {1'b0, oSum} + {{(ACC_WIDTH - 7){1'b0}}, iProduct};

    // Wrap or clamp the accumulated value.
    always_comb begin
`ifdef IMUL_MAC_SATURATE_EN
        if (sum_ext[ACC_WIDTH] || oOverflow) acc_nxt = '1;
        else                                 acc_nxt = sum_ext[ACC_WIDTH-1:0];
`else
        acc_nxt = sum_ext[ACC_WIDTH-1:0];
`endif
    end

    // Accumulator and sticky overflow; cleared when the result is taken.
    // mul_v is never set in OUT, so accumulate and clear cannot collide.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oSum      <= '0;
            oOverflow <= 1'b0;
        end else if (xfer) begin
            oSum      <= '0;
            oOverflow <= 1'b0;
        end else if (mul_v) begin
            oSum <= acc_nxt;
            if (sum_ext[ACC_WIDTH]) oOverflow <= 1'b1;
        end
    end

endmodule
